// File: rtl/sys_bus_sram.sv
// sys_bus_sram: word-addressed SRAM behind a request/response bus with configurable response latency
// Ports: clock_i/reset_n_i (async active-low); rw_address_i byte address;
//   read_request_i/write_request_i one-cycle request pulses; write_data_i/write_strobe_i write payload;
//   read_data_o last read word; read_response_o/write_response_o one-cycle completion pulses.
module sys_bus_sram #(
  parameter int MEM_SIZE_WORDS = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic        clock_i,
  input  logic        reset_n_i,
  input  logic [31:0] rw_address_i,
  input  logic        read_request_i,
  input  logic        write_request_i,
  input  logic [31:0] write_data_i,
  input  logic [3:0]  write_strobe_i,
  output logic [31:0] read_data_o,
  output logic        read_response_o,
  output logic        write_response_o
);
  localparam int AW = $clog2(MEM_SIZE_WORDS);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam logic [3:0] WS_LOAD = 4'(WAIT_STATES - 1);
  logic [31:0] mem [MEM_SIZE_WORDS];
  logic [1:0] state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0] strb_q, strb_d;
  logic wr_q, wr_d;
  logic [31:0] rdata_q, rdata_d;
  logic rresp_q, rresp_d, wresp_q, wresp_d;
  logic accept, go_resp, c_wr;
  logic [AW-1:0] c_addr;
  logic [31:0] c_wdata;
  logic [3:0] c_strb;
  logic unused_addr_bits;
  assign unused_addr_bits = ^{rw_address_i[31:AW+2], rw_address_i[1:0]};
  // With no wait states the access completes on the accepting edge, so it uses the live
  // inputs; otherwise it completes from the captured copy when the countdown expires.
  always_comb begin
    accept  = state_q != S_WAIT && (read_request_i || write_request_i);
    go_resp = WAIT_STATES == 0 ? accept : state_q == S_WAIT && cnt_q == 4'd0;
    c_addr  = WAIT_STATES == 0 ? rw_address_i[AW+1:2] : addr_q;
    c_wdata = WAIT_STATES == 0 ? write_data_i : wdata_q;
    c_strb  = WAIT_STATES == 0 ? write_strobe_i : strb_q;
    c_wr    = WAIT_STATES == 0 ? write_request_i : wr_q;
    addr_d  = accept ? rw_address_i[AW+1:2] : addr_q;
    wdata_d = accept ? write_data_i : wdata_q;
    strb_d  = accept ? write_strobe_i : strb_q;
    wr_d    = accept ? write_request_i : wr_q;
    state_d = go_resp ? S_RESP : accept || state_q == S_WAIT ? S_WAIT : S_IDLE;
    cnt_d   = accept && WAIT_STATES != 0 ? WS_LOAD :
              state_q == S_WAIT && cnt_q != 4'd0 ? cnt_q - 4'd1 : cnt_q;
    rdata_d = go_resp && !c_wr ? mem[c_addr] : rdata_q;
    rresp_d = go_resp && !c_wr;
    wresp_d = go_resp && c_wr;
  end
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      strb_q  <= '0;
      wr_q    <= 1'b0;
      rdata_q <= '0;
      rresp_q <= 1'b0;
      wresp_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      strb_q  <= strb_d;
      wr_q    <= wr_d;
      rdata_q <= rdata_d;
      rresp_q <= rresp_d;
      wresp_q <= wresp_d;
    end
  end
  // Memory is never reset; gating on reset_n_i drops a write coinciding with reset.
  always_ff @(posedge clock_i) begin
    if (reset_n_i && go_resp && c_wr)
      for (int k = 0; k < 4; k++)
        if (c_strb[k]) mem[c_addr][8*k +: 8] <= c_wdata[8*k +: 8];
  end
  assign read_data_o      = rdata_q;
  assign read_response_o  = rresp_q;
  assign write_response_o = wresp_q;
endmodule

// File: tb/tb_sys_bus_sram.sv
// tb_sys_bus_sram: directed bench for sys_bus_sram with zero, two and three wait states
module tb_sys_bus_sram;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rd_req = 1'b0, wr_req = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic [3:0] strb = '0;
  logic [31:0] rdata0, rdata2, rdata3;
  logic rresp0, wresp0, rresp2, wresp2, rresp3, wresp3;
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;
  sys_bus_sram #(.MEM_SIZE_WORDS(1024), .WAIT_STATES(0)) u0 (
    .clock_i(clk), .reset_n_i(rst_n), .rw_address_i(addr), .read_request_i(rd_req),
    .write_request_i(wr_req), .write_data_i(wdata), .write_strobe_i(strb),
    .read_data_o(rdata0), .read_response_o(rresp0), .write_response_o(wresp0));
  sys_bus_sram #(.MEM_SIZE_WORDS(1024), .WAIT_STATES(2)) u2 (
    .clock_i(clk), .reset_n_i(rst_n), .rw_address_i(addr), .read_request_i(rd_req),
    .write_request_i(wr_req), .write_data_i(wdata), .write_strobe_i(strb),
    .read_data_o(rdata2), .read_response_o(rresp2), .write_response_o(wresp2));
  sys_bus_sram #(.MEM_SIZE_WORDS(1024), .WAIT_STATES(3)) u3 (
    .clock_i(clk), .reset_n_i(rst_n), .rw_address_i(addr), .read_request_i(rd_req),
    .write_request_i(wr_req), .write_data_i(wdata), .write_strobe_i(strb),
    .read_data_o(rdata3), .read_response_o(rresp3), .write_response_o(wresp3));
  task automatic drive(input logic rd, input logic wr, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] s);
    @(negedge clk);
    rd_req = rd;
    wr_req = wr;
    addr = a;
    wdata = d;
    strb = s;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rd_req = 1'b0;
      wr_req = 1'b0;
    end
  endtask
  task automatic test_reset();
    #12;
    tests++; if ({rdata0, rresp0, wresp0} !== 34'h0) begin fails++; $display("FAIL reset_ws0 got %h want 0", {rdata0, rresp0, wresp0}); end
    tests++; if ({rdata2, rresp2, wresp2} !== 34'h0) begin fails++; $display("FAIL reset_ws2 got %h want 0", {rdata2, rresp2, wresp2}); end
    tests++; if ({rdata3, rresp3, wresp3} !== 34'h0) begin fails++; $display("FAIL reset_ws3 got %h want 0", {rdata3, rresp3, wresp3}); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  task automatic test_basic();
    drive(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    idle(1);
    tests++; if ({wresp0, rresp0} !== 2'b10) begin fails++; $display("FAIL basic_wresp got %b want 10", {wresp0, rresp0}); end
    idle(1);
    tests++; if (wresp0 !== 1'b0) begin fails++; $display("FAIL basic_wresp_pulse got %b want 0", wresp0); end
    drive(1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
    idle(1);
    tests++; if ({rresp0, wresp0} !== 2'b10) begin fails++; $display("FAIL basic_rresp got %b want 10", {rresp0, wresp0}); end
    tests++; if (rdata0 !== 32'hDEADBEEF) begin fails++; $display("FAIL basic_rdata got %h want deadbeef", rdata0); end
    idle(1);
    tests++; if (rresp0 !== 1'b0 || rdata0 !== 32'hDEADBEEF) begin fails++; $display("FAIL basic_hold got %b/%h want 0/deadbeef", rresp0, rdata0); end
  endtask
  task automatic test_strobe();
    drive(1'b0, 1'b1, 32'h10, 32'h00005500, 4'b0010);
    idle(1);
    tests++; if (wresp0 !== 1'b1) begin fails++; $display("FAIL strobe_wresp got %b want 1", wresp0); end
    drive(1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
    idle(1);
    tests++; if (rdata0 !== 32'hDEAD55EF) begin fails++; $display("FAIL strobe_rdata got %h want dead55ef", rdata0); end
    drive(1'b0, 1'b1, 32'h10, 32'h11111111, 4'b0000);
    idle(1);
    tests++; if (wresp0 !== 1'b1 || rdata0 !== 32'hDEAD55EF) begin fails++; $display("FAIL strobe0_wresp got %b/%h want 1/dead55ef", wresp0, rdata0); end
    drive(1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
    idle(1);
    tests++; if (rresp0 !== 1'b1 || rdata0 !== 32'hDEAD55EF) begin fails++; $display("FAIL strobe0_nochange got %b/%h want 1/dead55ef", rresp0, rdata0); end
  endtask
  task automatic test_simul();
    drive(1'b1, 1'b1, 32'h8, 32'hA5A5A5A5, 4'hF);
    idle(1);
    tests++; if ({wresp0, rresp0} !== 2'b10) begin fails++; $display("FAIL simul_resp got %b want 10", {wresp0, rresp0}); end
    drive(1'b1, 1'b0, 32'h8, 32'h0, 4'h0);
    idle(1);
    tests++; if (rresp0 !== 1'b1 || rdata0 !== 32'hA5A5A5A5) begin fails++; $display("FAIL simul_read got %b/%h want 1/a5a5a5a5", rresp0, rdata0); end
  endtask
  task automatic test_back_to_back();
    drive(1'b0, 1'b1, 32'h00001004, 32'h12345678, 4'hF);
    drive(1'b1, 1'b0, 32'h00000004, 32'h0, 4'h0);
    tests++; if ({wresp0, rresp0} !== 2'b10) begin fails++; $display("FAIL b2b_wresp got %b want 10", {wresp0, rresp0}); end
    idle(1);
    tests++; if ({rresp0, wresp0} !== 2'b10) begin fails++; $display("FAIL b2b_rresp got %b want 10", {rresp0, wresp0}); end
    tests++; if (rdata0 !== 32'h12345678) begin fails++; $display("FAIL alias_rdata got %h want 12345678", rdata0); end
  endtask
  task automatic test_wait();
    idle(6);
    drive(1'b0, 1'b1, 32'h20, 32'hCAFEF00D, 4'hF);
    idle(6);
    drive(1'b1, 1'b0, 32'h20, 32'h0, 4'h0);
    for (int i = 1; i <= 3; i++) begin
      drive(1'b0, 1'b1, 32'h20, 32'h0, 4'hF);
      tests++; if ({rresp3, wresp3} !== 2'b00) begin fails++; $display("FAIL wait_early_%0d got %b want 00", i, {rresp3, wresp3}); end
    end
    idle(1);
    tests++; if ({rresp3, wresp3} !== 2'b10) begin fails++; $display("FAIL wait_resp got %b want 10", {rresp3, wresp3}); end
    tests++; if (rdata3 !== 32'hCAFEF00D) begin fails++; $display("FAIL wait_rdata got %h want cafef00d", rdata3); end
    idle(1);
    tests++; if ({rresp3, wresp3} !== 2'b00) begin fails++; $display("FAIL wait_single got %b want 00", {rresp3, wresp3}); end
    idle(4);
    drive(1'b1, 1'b0, 32'h20, 32'h0, 4'h0);
    idle(4);
    tests++; if (rresp3 !== 1'b1 || rdata3 !== 32'hCAFEF00D) begin fails++; $display("FAIL wait_ignored_writes got %b/%h want 1/cafef00d", rresp3, rdata3); end
  endtask
  task automatic test_reset_mid();
    idle(4);
    drive(1'b0, 1'b1, 32'h40, 32'h0, 4'hF);
    idle(4);
    drive(1'b0, 1'b1, 32'h44, 32'h77, 4'hF);
    idle(4);
    drive(1'b1, 1'b0, 32'h44, 32'h0, 4'h0);
    idle(3);
    tests++; if (rresp2 !== 1'b1 || rdata2 !== 32'h77) begin fails++; $display("FAIL ws2_read got %b/%h want 1/77", rresp2, rdata2); end
    idle(2);
    drive(1'b0, 1'b1, 32'h40, 32'hFFFFFFFF, 4'hF);
    idle(1);
    #1 rst_n = 1'b0;
    #1;
    tests++; if ({rdata2, rresp2, wresp2} !== 34'h0) begin fails++; $display("FAIL async_reset_ws2 got %h want 0", {rdata2, rresp2, wresp2}); end
    tests++; if (rdata0 !== 32'h0) begin fails++; $display("FAIL async_reset_ws0 got %h want 0", rdata0); end
    idle(2);
    rst_n = 1'b1;
    rd_req = 1'b1;
    addr = 32'h40;
    idle(1);
    tests++; if (rresp0 !== 1'b1 || rdata0 !== 32'hFFFFFFFF) begin fails++; $display("FAIL first_req_ws0 got %b/%h want 1/ffffffff", rresp0, rdata0); end
    tests++; if (rresp2 !== 1'b0) begin fails++; $display("FAIL ws2_lat1 got %b want 0", rresp2); end
    idle(1);
    tests++; if (rresp2 !== 1'b0) begin fails++; $display("FAIL ws2_lat2 got %b want 0", rresp2); end
    idle(1);
    tests++; if (rresp2 !== 1'b1 || rdata2 !== 32'h0) begin fails++; $display("FAIL reset_discard got %b/%h want 1/0", rresp2, rdata2); end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_strobe();
    test_simul();
    test_back_to_back();
    test_wait();
    test_reset_mid();
    idle(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
